// File: rtl/upuart_pkg.sv
// Shared upuart definitions: receiver state encoding, data-bit config encoding
// and the 3-sample majority vote.
package upuart_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StParity  = 3'd3,
    StStop    = 3'd4,
    StBrkWait = 3'd5
  } rx_state_e;

  // cfg_dbits holds (number of data bits - 5)
  localparam logic [1:0] Dbits5 = 2'b00;
  localparam logic [1:0] Dbits6 = 2'b01;
  localparam logic [1:0] Dbits7 = 2'b10;
  localparam logic [1:0] Dbits8 = 2'b11;

  function automatic logic upuart_vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/upuart_sync.sv
// Multi-stage synchroniser for an asynchronous, idle-high serial line.
module upuart_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] ff_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[SYNC-2:0], d};
    end
  end

  assign q = ff_q[SYNC-1];

endmodule

// File: rtl/upuart_rx_cfg.sv
// Configurable UART receiver: 5..8 data bits, optional parity, 1/2 stop bits,
// oversampled with a 3-sample majority vote; reports parity, framing and break.
module upuart_rx_cfg
  import upuart_pkg::*;
#(
  parameter int unsigned OVS  = 16,
  parameter int unsigned SYNC = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       uclk,
  input  logic       rxd,
  input  logic [1:0] cfg_dbits,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       cfg_stop2,
  output logic [7:0] data_out,
  output logic       data_wr,
  output logic       perr,
  output logic       ferr,
  output logic       brk,
  output logic       busy
);

  localparam int unsigned TW = $clog2(OVS);
  localparam logic [TW-1:0] TickS0   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TickS1   = TW'(OVS / 2);
  localparam logic [TW-1:0] TickVote = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] TickLast = TW'(OVS - 1);

  logic rxs;

  upuart_sync #(
    .SYNC(SYNC)
  ) u_sync (
    .clk (clk),
    .nrst(nrst),
    .d   (rxd),
    .q   (rxs)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          smp0_q, smp0_d, smp1_q, smp1_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          perr_acc_q, perr_acc_d;
  logic          ferr_acc_q, ferr_acc_d;
  logic          zero_q, zero_d;
  logic          one_q, one_d;
  logic [1:0]    dbits_q, dbits_d;
  logic          par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_wr_q, data_wr_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;

  logic vote, at_vote, at_wrap, ferr_nx, zero_nx;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    zero_d     = zero_q;
    one_d      = one_q;
    dbits_d    = dbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    data_out_d = data_out_q;
    data_wr_d  = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    vote       = upuart_vote3(smp0_q, smp1_q, rxs);
    at_vote    = (tick_q == TickVote);
    at_wrap    = (tick_q == TickLast);
    ferr_nx    = ferr_acc_q | ~vote;
    zero_nx    = zero_q & ~vote;

    if (uclk) begin
      tick_d = at_wrap ? '0 : tick_q + TW'(1);
      if (tick_q == TickS0) smp0_d = rxs;
      if (tick_q == TickS1) smp1_d = rxs;

      unique case (state_q)
        StIdle: begin
          tick_d = '0;
          if (!rxs) begin
            // Config is frozen for the whole frame from here on
            dbits_d    = cfg_dbits;
            par_en_d   = cfg_par_en;
            par_odd_d  = cfg_par_odd;
            stop2_d    = cfg_stop2;
            shift_d    = '0;
            par_d      = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
            zero_d     = 1'b1;
            bit_d      = '0;
            state_d    = StStart;
          end
        end
        StStart: begin
          if (at_vote && vote) begin
            state_d = StIdle;
          end else if (at_wrap) begin
            bit_d   = '0;
            state_d = StData;
          end
        end
        StData: begin
          if (at_vote) begin
            shift_d[bit_q] = vote;
            par_d          = par_q ^ vote;
            zero_d         = zero_nx;
          end
          if (at_wrap) begin
            if (bit_q == {1'b0, dbits_q} + 3'd4) begin
              bit_d   = '0;
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (at_vote) begin
            perr_acc_d = vote ^ par_q ^ par_odd_q;
            zero_d     = zero_nx;
          end
          if (at_wrap) begin
            bit_d   = '0;
            state_d = StStop;
          end
        end
        StStop: begin
          if (at_vote) begin
            ferr_acc_d = ferr_nx;
            zero_d     = zero_nx;
            if (bit_q[0] == stop2_q) begin
              // Leave mid stop bit so the next start edge can be caught early
              data_wr_d  = 1'b1;
              data_out_d = shift_q;
              perr_d     = perr_acc_q;
              ferr_d     = ferr_nx;
              brk_d      = zero_nx;
              one_d      = 1'b0;
              state_d    = zero_nx ? StBrkWait : StIdle;
            end
          end else if (at_wrap) begin
            bit_d = bit_q + 3'd1;
          end
        end
        StBrkWait: begin
          if (rxs) begin
            one_d = 1'b1;
            if (one_q) state_d = StIdle;
          end else begin
            one_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      zero_q     <= 1'b0;
      one_q      <= 1'b0;
      dbits_q    <= Dbits8;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_out_q <= '0;
      data_wr_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      zero_q     <= zero_d;
      one_q      <= one_d;
      dbits_q    <= dbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      data_out_q <= data_out_d;
      data_wr_q  <= data_wr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign data_out = data_out_q;
  assign data_wr  = data_wr_q;
  assign perr     = perr_q;
  assign ferr     = ferr_q;
  assign brk      = brk_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_upuart_rx_cfg.sv
// Bench for upuart_rx_cfg: table-driven and random frames checked against a
// frame-level model, plus break, glitch, reset and uclk-stall sequences.
module tb_upuart_rx_cfg;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       uclk = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] cfg_dbits = 2'b11;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic [7:0] data_out;
  logic       data_wr, perr, ferr, brk, busy;

  upuart_rx_cfg #(
    .OVS (OVS),
    .SYNC(2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .uclk       (uclk),
    .rxd        (rxd),
    .cfg_dbits  (cfg_dbits),
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_stop2  (cfg_stop2),
    .data_out   (data_out),
    .data_wr    (data_wr),
    .perr       (perr),
    .ferr       (ferr),
    .brk        (brk),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // uclk: one clk wide every other clk, can be frozen
  logic uclk_run = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      uclk = uclk_run && !uclk;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } rx_t;

  rx_t q[$];
  int  n_wide = 0;
  logic wr_prev = 1'b0;

  always @(negedge clk) begin
    if (nrst && data_wr) q.push_back('{d: data_out, p: perr, f: ferr, b: brk});
    if (data_wr && wr_prev) n_wide++;
    wr_prev = data_wr;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_ticks(input logic v, input int n);
    rxd = v;
    for (int k = 0; k < n;) begin
      @(posedge clk);
      if (uclk) k++;
    end
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         nb;
    logic       pe;
    logic       po;
    logic       s2;
    logic       badpar;
    logic [1:0] stops;
    logic       stall;
  } vec_t;

  // Sends one frame, then checks exactly one strobe with model-predicted fields
  task automatic run_frame(input string name, input vec_t v);
    logic [7:0] mask, d;
    logic       pbit, exp_f, exp_b;
    rx_t        r;
    mask  = 8'((9'd1 << v.nb) - 9'd1);
    d     = v.data & mask;
    pbit  = (^d) ^ v.po ^ v.badpar;
    exp_f = (v.stops[0] == 1'b0) || (v.s2 && v.stops[1] == 1'b0);
    exp_b = (d == 8'h00) && (!v.pe || !pbit) && !v.stops[0] && (!v.s2 || !v.stops[1]);
    cfg_dbits   = 2'(v.nb - 5);
    cfg_par_en  = v.pe;
    cfg_par_odd = v.po;
    cfg_stop2   = v.s2;
    hold_ticks(1'b0, OVS);
    cfg_dbits   = 2'($urandom);
    cfg_par_en  = 1'($urandom);
    cfg_par_odd = 1'($urandom);
    cfg_stop2   = 1'($urandom);
    for (int i = 0; i < v.nb; i++) begin
      if (v.stall && i == 3) begin
        hold_ticks(d[i], 5);
        uclk_run = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk({name, " busy in stall"}, 32'(busy), 32'd1);
        uclk_run = 1'b1;
        hold_ticks(d[i], OVS - 5);
      end else begin
        hold_ticks(d[i], OVS);
      end
    end
    if (v.pe) hold_ticks(pbit, OVS);
    hold_ticks(v.stops[0], OVS);
    if (v.s2) hold_ticks(v.stops[1], OVS);
    hold_ticks(1'b1, OVS);
    chk({name, " strobes"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      r = q.pop_front();
      chk({name, " data"}, 32'(r.d), 32'(d));
      chk({name, " perr"}, 32'(r.p), 32'(v.pe & v.badpar));
      chk({name, " ferr"}, 32'(r.f), 32'(exp_f));
      chk({name, " brk"}, 32'(r.b), 32'(exp_b));
    end
    q.delete();
  endtask

  vec_t tbl[8];

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{data: 8'hA5, nb: 8, pe: 0, po: 0, s2: 0, badpar: 0, stops: 2'b11, stall: 0};
    tbl[1] = '{data: 8'h35, nb: 7, pe: 1, po: 0, s2: 0, badpar: 1, stops: 2'b11, stall: 0};
    tbl[2] = '{data: 8'h12, nb: 7, pe: 1, po: 0, s2: 0, badpar: 0, stops: 2'b11, stall: 0};
    tbl[3] = '{data: 8'h1F, nb: 5, pe: 1, po: 1, s2: 1, badpar: 0, stops: 2'b01, stall: 0};
    tbl[4] = '{data: 8'h2A, nb: 6, pe: 1, po: 0, s2: 1, badpar: 0, stops: 2'b10, stall: 0};
    tbl[5] = '{data: 8'h00, nb: 8, pe: 1, po: 1, s2: 0, badpar: 0, stops: 2'b11, stall: 0};
    tbl[6] = '{data: 8'h00, nb: 8, pe: 1, po: 0, s2: 0, badpar: 0, stops: 2'b00, stall: 0};
    tbl[7] = '{data: 8'h96, nb: 8, pe: 0, po: 0, s2: 0, badpar: 0, stops: 2'b11, stall: 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset data_wr", 32'(data_wr), 32'h0);
    chk("reset flags", {29'd0, perr, ferr, brk}, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    nrst = 1'b1;
    hold_ticks(1'b1, OVS);

    for (int i = 0; i < 8; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Break: 20 bit times low gives one strobe, then waits for 2 high ticks
    cfg_dbits = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    hold_ticks(1'b0, 20 * OVS);
    chk("break strobes", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      chk("break data", 32'(q[0].d), 32'h0);
      chk("break flags", {29'd0, q[0].p, q[0].f, q[0].b}, 32'b011);
    end
    q.delete();
    hold_ticks(1'b1, 1);
    hold_ticks(1'b0, 2 * OVS);
    chk("break single high", 32'(q.size()), 32'd0);
    chk("break still waiting", 32'(busy), 32'd1);
    hold_ticks(1'b1, 4);
    chk("break released", 32'(busy), 32'd0);
    v = '{data: 8'h55, nb: 8, pe: 0, po: 0, s2: 0, badpar: 0, stops: 2'b11, stall: 0};
    run_frame("after break", v);

    // Glitch shorter than half a bit is a false start
    hold_ticks(1'b0, 3);
    hold_ticks(1'b1, 4);
    chk("glitch busy", 32'(busy), 32'd1);
    hold_ticks(1'b1, OVS);
    chk("glitch idle", 32'(busy), 32'd0);
    chk("glitch strobes", 32'(q.size()), 32'd0);

    // Reset in the middle of the data bits of 0xC3
    hold_ticks(1'b0, OVS);
    hold_ticks(1'b1, OVS);
    hold_ticks(1'b1, OVS);
    hold_ticks(1'b0, OVS / 2);
    nrst = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset data_out", 32'(data_out), 32'h0);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    nrst = 1'b1;
    hold_ticks(1'b1, OVS);
    chk("midreset strobes", 32'(q.size()), 32'd0);
    v = '{data: 8'h3C, nb: 8, pe: 0, po: 0, s2: 0, badpar: 0, stops: 2'b11, stall: 0};
    run_frame("after reset", v);

    for (int i = 0; i < 25; i++) begin
      v.data   = 8'($urandom);
      v.nb     = 5 + int'($urandom_range(0, 3));
      v.pe     = 1'($urandom);
      v.po     = 1'($urandom);
      v.s2     = 1'($urandom);
      v.badpar = ($urandom_range(0, 3) == 0);
      v.stops  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      v.stall  = ($urandom_range(0, 7) == 0);
      run_frame($sformatf("rand%0d", i), v);
    end

    chk("data_wr one clk wide", 32'(n_wide), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
